// File: rtl/icon_counter_object.sv
// HUD row of up to MAX_ICONS icon slots showing an internally held saturating count,
// with a blink on the slot that changed. Outputs are registered one clock after the pixel.
module icon_counter_object #(
    parameter int         TOP_X        = 548,
    parameter int         TOP_Y        = 30,
    parameter int         ICON_W       = 16,
    parameter int         ICON_H       = 16,
    parameter int         ICON_GAP     = 4,
    parameter int         MAX_ICONS    = 4,
    parameter int         INIT_COUNT   = 0,
    parameter int         BLINK_FRAMES = 30,
    parameter int         BLINK_HALF   = 4,
    parameter logic [7:0] OBJECT_COLOR = 8'h5b
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        inc,
    input  logic        dec,
    input  logic        load,
    input  logic [4:0]  load_value,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic [3:0]  iconIndex,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    localparam int         PITCH = ICON_W + ICON_GAP;
    localparam logic [4:0] MAX_C = 5'(MAX_ICONS);

    typedef enum logic [1:0] {IDLE, BLINK_UP, BLINK_DOWN} state_t;

    state_t      state;
    logic [15:0] frames_left;
    logic [15:0] half_cnt;
    logic        phase;
    logic [3:0]  blink_idx;

    logic inc_ok;
    logic dec_ok;

    assign inc_ok = inc && !dec && (count < MAX_C);
    assign dec_ok = dec && !inc && (count != 5'd0);
    assign full   = (count == MAX_C);
    assign empty  = (count == 5'd0);

    always_ff @(posedge clk) begin
        if (resetN) begin
            count       <= 5'(INIT_COUNT);
            state       <= IDLE;
            frames_left <= '0;
            half_cnt    <= '0;
            phase       <= 1'b0;
            blink_idx   <= '0;
        end else if (load) begin
            count       <= (load_value > MAX_C) ? MAX_C : load_value;
            state       <= IDLE;
            frames_left <= '0;
            half_cnt    <= '0;
            phase       <= 1'b0;
        end else if (inc_ok) begin
            count       <= count + 5'd1;
            state       <= BLINK_UP;
            blink_idx   <= count[3:0];
            frames_left <= 16'(BLINK_FRAMES);
            half_cnt    <= '0;
            phase       <= 1'b0;
        end else if (dec_ok) begin
            count       <= count - 5'd1;
            state       <= BLINK_DOWN;
            blink_idx   <= 4'(count - 5'd1);
            frames_left <= 16'(BLINK_FRAMES);
            half_cnt    <= '0;
            phase       <= 1'b0;
        end else if (state != IDLE && startOfFrame) begin
            frames_left <= frames_left - 16'd1;
            if (frames_left == 16'd1)
                state <= IDLE;
            if (half_cnt == 16'(BLINK_HALF - 1)) begin
                half_cnt <= '0;
                phase    <= ~phase;
            end else begin
                half_cnt <= half_cnt + 16'd1;
            end
        end
    end

    // Slots are disjoint, so at most one hit bit is set; boundaries are elaboration constants.
    logic [11:0]          px12;
    logic [11:0]          py12;
    logic                 y_in;
    logic [MAX_ICONS-1:0] hit;
    logic [10:0]          slot_left [MAX_ICONS];

    assign px12 = {1'b0, pixelX};
    assign py12 = {1'b0, pixelY};
    assign y_in = (py12 >= 12'(TOP_Y)) && (py12 < 12'(TOP_Y + ICON_H));

    for (genvar gi = 0; gi < MAX_ICONS; gi++) begin : g_slot
        localparam int LO = TOP_X + gi * PITCH;
        if (LO < 2048) begin : g_on
            assign hit[gi]       = y_in && (px12 >= 12'(LO)) && (px12 < 12'(LO + ICON_W));
            assign slot_left[gi] = 11'(LO);
        end else begin : g_off
            assign hit[gi]       = 1'b0;
            assign slot_left[gi] = '0;
        end
    end

    logic        hit_any;
    logic [3:0]  hit_idx;
    logic [10:0] hit_left;
    logic        vis;

    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        hit_left = '0;
        for (int i = 0; i < MAX_ICONS; i++) begin
            if (hit[i]) begin
                hit_any  = 1'b1;
                hit_idx  = 4'(i);
                hit_left = slot_left[i];
            end
        end
        vis = hit_any && ({1'b0, hit_idx} < count);
        // Phase 0 inverts the changed slot: a new icon starts hidden, a removed one lingers.
        if (hit_any && hit_idx == blink_idx && !phase) begin
            if (state == BLINK_UP)
                vis = 1'b0;
            else if (state == BLINK_DOWN)
                vis = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN || !vis) begin
            drawingRequest <= 1'b0;
            RGBout         <= 8'hFF;
            offsetX        <= '0;
            offsetY        <= '0;
            iconIndex      <= '0;
        end else begin
            drawingRequest <= 1'b1;
            RGBout         <= OBJECT_COLOR;
            offsetX        <= pixelX - hit_left;
            offsetY        <= pixelY - 11'(TOP_Y);
            iconIndex      <= hit_idx;
        end
    end

endmodule

// File: tb/tb_icon_counter_object.sv
// Directed stimulus for icon_counter_object; expected pixel responses are queued by the
// driver and compared by an independent monitor one clock later.
module tb_icon_counter_object;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        inc = 1'b0;
    logic        dec = 1'b0;
    logic        load = 1'b0;
    logic [4:0]  load_value = '0;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [3:0]  iconIndex;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    icon_counter_object dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .inc(inc), .dec(dec), .load(load),
        .load_value(load_value), .count(count), .full(full), .empty(empty),
        .offsetX(offsetX), .offsetY(offsetY), .iconIndex(iconIndex),
        .drawingRequest(drawingRequest), .RGBout(RGBout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        dr;
        logic [3:0]  idx;
        logic [10:0] ox;
        logic [10:0] oy;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    logic probe_d = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) probe_d <= probe;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (probe_d) begin
            if (sb.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("drawingRequest", int'(drawingRequest), int'(e.dr));
                chk("RGBout", int'(RGBout), e.dr ? 32'h5b : 32'hff);
                chk("offsetX", int'(offsetX), int'(e.ox));
                chk("offsetY", int'(offsetY), int'(e.oy));
                chk("iconIndex", int'(iconIndex), int'(e.idx));
                chk("count", int'(count), int'(e.cnt));
                chk("full", int'(full), int'(e.cnt == 5'd4));
                chk("empty", int'(empty), int'(e.cnt == 5'd0));
            end
        end
    end

    task automatic probe_exp(input int x, input int y, input logic dr, input int idx,
                             input int ox, input int oy, input int cnt);
        exp_t e;
        e.dr  = dr;
        e.idx = 4'(idx);
        e.ox  = 11'(ox);
        e.oy  = 11'(oy);
        e.cnt = 5'(cnt);
        pixelX = 11'(x);
        pixelY = 11'(y);
        sb.push_back(e);
        probe = 1'b1;
        @(negedge clk);
        probe = 1'b0;
    endtask

    // Slot i occupies x 548+20i .. 563+20i, y 30..45; vis_mask says which slots should show.
    task automatic probe_px(input int x, input int y, input logic [3:0] vis_mask, input int cnt);
        logic dr = 1'b0;
        int   idx = 0, ox = 0, oy = 0;
        for (int i = 0; i < 4; i++) begin
            if (x >= 548 + 20*i && x < 564 + 20*i && y >= 30 && y < 46 && vis_mask[i]) begin
                dr = 1'b1; idx = i; ox = x - (548 + 20*i); oy = y - 30;
            end
        end
        probe_exp(x, y, dr, idx, ox, oy, cnt);
    endtask

    task automatic drive(input logic i, input logic d, input logic l, input int lv, input logic r);
        inc = i; dec = d; load = l; load_value = 5'(lv); resetN = r;
        @(negedge clk);
        inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = '0; resetN = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    initial begin
        logic v;
        repeat (3) @(negedge clk);
        resetN = 1'b0;

        // Empty counter: nothing drawn anywhere around the row.
        probe_exp(548, 30, 1'b0, 0, 0, 0, 0);
        for (int x = 540; x <= 640; x += 3) begin
            probe_px(x, 30, 4'h0, 0);
            probe_px(x, 45, 4'h0, 0);
        end

        repeat (3) drive(1, 0, 0, 0, 0);
        frames(31);
        probe_exp(588, 35, 1'b1, 2, 0, 5, 3);
        probe_exp(564, 30, 1'b0, 0, 0, 0, 3);
        probe_exp(548, 30, 1'b1, 0, 0, 0, 3);
        probe_exp(603, 45, 1'b1, 2, 15, 15, 3);
        probe_exp(608, 30, 1'b0, 0, 0, 0, 3);
        probe_exp(588, 46, 1'b0, 0, 0, 0, 3);
        probe_exp(588, 29, 1'b0, 0, 0, 0, 3);
        probe_exp(584, 40, 1'b0, 0, 0, 0, 3);

        // Blink up of slot 3: hidden for 4 frames, shown for 4, ... steady after 30.
        drive(1, 0, 0, 0, 0);
        for (int n = 0; n < 33; n++) begin
            v = (n < 30) ? ((n / 4) % 2 == 1) : 1'b1;
            probe_px(612, 38, {v, 3'b111}, 4);
            frames(1);
        end
        drive(1, 0, 0, 0, 0);
        probe_exp(608, 30, 1'b1, 3, 0, 0, 4);

        // Blink down: ghost of slot 3 shown first, gone after 30 frames.
        drive(0, 1, 0, 0, 0);
        for (int n = 0; n < 33; n++) begin
            v = (n < 30) ? ((n / 4) % 2 == 0) : 1'b0;
            probe_px(620, 44, {v, 3'b111}, 3);
            frames(1);
        end

        drive(1, 1, 0, 0, 0);
        probe_exp(608, 30, 1'b0, 0, 0, 0, 3);
        probe_exp(568, 31, 1'b1, 1, 0, 1, 3);
        drive(1, 0, 1, 9, 0);
        probe_exp(623, 45, 1'b1, 3, 15, 15, 4);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        probe_exp(548, 30, 1'b0, 0, 0, 0, 0);

        // Reset lands mid-blink while slot 0 would otherwise be drawn.
        drive(0, 0, 1, 3, 0);
        drive(1, 0, 0, 0, 0);
        frames(10);
        probe_exp(548, 30, 1'b1, 0, 0, 0, 4);
        resetN = 1'b1;
        probe_exp(548, 30, 1'b0, 0, 0, 0, 0);
        resetN = 1'b0;
        probe_exp(612, 30, 1'b0, 0, 0, 0, 0);

        // Reset in the same cycle as inc wins.
        drive(0, 0, 1, 2, 0);
        probe_exp(570, 33, 1'b1, 1, 2, 3, 2);
        drive(1, 0, 0, 0, 1);
        probe_exp(548, 30, 1'b0, 0, 0, 0, 0);
        probe_exp(568, 30, 1'b0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
